// File: rtl/mitch_pkg.sv
// Shared types and constants for the Mitchell log-domain approximate arithmetic blocks.
// Carries the fixed operand/result widths, the saturation codes and the per-stage payloads.
package mitch_pkg;

  localparam int WIDTH = 16;
  localparam int QW    = 32;
  localparam int FRAC  = 15;

  localparam logic [QW-1:0] Q_POS_SAT = 32'h7FFF_FFFF;
  localparam logic [QW-1:0] Q_NEG_SAT = 32'h8000_0000;

  // Normalised logs {k, f} of both magnitudes plus the sign and zero flags
  typedef struct packed {
    logic [FRAC+3:0] la;
    logic [FRAC+3:0] lb;
    logic            sign;
    logic            za;
    logic            zb;
  } s1_t;

  typedef struct packed {
    logic signed [4:0] kd;
    logic [FRAC-1:0]   fd;
    logic              sign;
    logic              za;
    logic              zb;
  } s2_t;

endpackage

// File: rtl/mitch_log16.sv
// Combinational Mitchell log of a 16-bit magnitude: leading-one index k and
// the 15 bits below that leading one as the linear mantissa approximation f.
module mitch_log16
  import mitch_pkg::*;
(
  input  logic [WIDTH-1:0] mag_i,
  output logic             zero_o,
  output logic [3:0]       k_o,
  output logic [FRAC-1:0]  f_o
);

  logic [3:0]       k_s;
  logic [WIDTH-1:0] norm_s;

  // Leading-one search; the highest set bit wins because it is visited last
  always_comb begin
    k_s = 4'd0;
    for (int i = 0; i < WIDTH; i++) begin
      k_s = mag_i[i] ? i[3:0] : k_s;
    end
  end

  assign norm_s = mag_i << (4'd15 - k_s);
  assign zero_o = (mag_i == 16'd0);
  assign k_o    = k_s;
  assign f_o    = norm_s[FRAC-1:0];

endmodule

// File: rtl/mitch_div_pipe.sv
// 3-stage elastic Mitchell approximate divider: normalise, log subtract, antilog.
// Output is a Q16.16 quotient with sign applied by one's complement.
module mitch_div_pipe
  import mitch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [QW-1:0]     q,
  output logic              div_by_zero
);

  logic v1_q, v2_q, v3_q;
  logic s1_en_s, s2_en_s, s3_en_s;
  s1_t  p1_d, p1_q;
  s2_t  p2_d, p2_q;
  logic [QW-1:0] q_d, q_q;
  logic          dbz_d, dbz_q;

  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic             za_s, zb_s;
  logic [3:0]       ka_s, kb_s;
  logic [FRAC-1:0]  fa_s, fb_s;
  logic [FRAC+4:0]  d_s;
  logic [5:0]       s_s, nsh_s;
  logic [QW-1:0]    m_s, mq_s;

  // A stage may load when it is empty or its contents move on this cycle
  assign s3_en_s   = ~v3_q | out_ready;
  assign s2_en_s   = ~v2_q | s3_en_s;
  assign s1_en_s   = ~v1_q | s2_en_s;
  assign in_ready  = s1_en_s;
  assign out_valid = v3_q;
  assign q         = q_q;
  assign div_by_zero = dbz_q;

  assign mag_a_s = x ^ {WIDTH{x[WIDTH-1]}};
  assign mag_b_s = y ^ {WIDTH{y[WIDTH-1]}};

  mitch_log16 u_log_a (.mag_i(mag_a_s), .zero_o(za_s), .k_o(ka_s), .f_o(fa_s));
  mitch_log16 u_log_b (.mag_i(mag_b_s), .zero_o(zb_s), .k_o(kb_s), .f_o(fb_s));

  // Stage 1 payload from the two log units
  always_comb begin
    p1_d      = '0;
    p1_d.la   = {ka_s, fa_s};
    p1_d.lb   = {kb_s, fb_s};
    p1_d.sign = x[WIDTH-1] ^ y[WIDTH-1];
    p1_d.za   = za_s;
    p1_d.zb   = zb_s;
  end

  // Stage 2: log difference split into signed integer part and fraction
  always_comb begin
    d_s       = {1'b0, p1_q.la} - {1'b0, p1_q.lb};
    p2_d      = '0;
    p2_d.kd   = d_s[FRAC+4:FRAC];
    p2_d.fd   = d_s[FRAC-1:0];
    p2_d.sign = p1_q.sign;
    p2_d.za   = p1_q.za;
    p2_d.zb   = p1_q.zb;
  end

  // Stage 3: antilog shift by kd+1 (range -15..16), then zero handling and sign
  always_comb begin
    s_s   = {p2_q.kd[4], p2_q.kd} + 6'd1;
    nsh_s = 6'd0 - s_s;
    m_s   = {16'h0000, 1'b1, p2_q.fd};
    if (s_s[5]) begin
      mq_s = m_s >> nsh_s;
    end else begin
      mq_s = m_s << s_s;
    end
    q_d   = {QW{p2_q.sign}} ^ mq_s;
    dbz_d = 1'b0;
    if (p2_q.zb) begin
      q_d   = p2_q.sign ? Q_NEG_SAT : Q_POS_SAT;
      dbz_d = 1'b1;
    end else if (p2_q.za) begin
      q_d   = 32'h0000_0000;
    end else begin
      q_d   = {QW{p2_q.sign}} ^ mq_s;
    end
  end

  // Pipeline registers; payloads move only alongside a valid item
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      p1_q  <= '0;
      p2_q  <= '0;
      q_q   <= 32'h0000_0000;
      dbz_q <= 1'b0;
    end else begin
      if (s1_en_s) v1_q <= in_valid;
      if (s1_en_s && in_valid) p1_q <= p1_d;
      if (s2_en_s) v2_q <= v1_q;
      if (s2_en_s && v1_q) p2_q <= p2_d;
      if (s3_en_s) v3_q <= v2_q;
      if (s3_en_s && v2_q) begin
        q_q   <= q_d;
        dbz_q <= dbz_d;
      end
    end
  end

endmodule

// File: tb/tb_mitch_div_pipe.sv
// Self-checking bench for mitch_div_pipe: directed vectors, backpressure, reset
// flush and a random valid/ready soak against an arithmetic reference model.
module tb_mitch_div_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] exp_q[$];
  bit          acc;
  bit          got_out;
  logic [31:0] last_q;
  logic        last_dbz;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_q;
  logic        hold_dbz;

  mitch_div_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, expv);
    end
  endtask

  // Mitchell quotient from the log-domain definition, computed with integers
  function automatic logic [32:0] model(input logic [15:0] xx, input logic [15:0] yy);
    int a, b, ka, kb, la, lb, d, fd, kd, s;
    longint mq;
    logic sg;
    logic [31:0] r;
    sg = xx[15] ^ yy[15];
    a  = xx[15] ? 65535 - int'(xx) : int'(xx);
    b  = yy[15] ? 65535 - int'(yy) : int'(yy);
    if (b == 0) return {1'b1, (sg ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    if (a == 0) return 33'd0;
    ka = 0;
    while ((1 << (ka + 1)) <= a) ka++;
    kb = 0;
    while ((1 << (kb + 1)) <= b) kb++;
    la = ka * 32768 + a * (1 << (15 - ka)) - 32768;
    lb = kb * 32768 + b * (1 << (15 - kb)) - 32768;
    d  = la - lb;
    fd = ((d % 32768) + 32768) % 32768;
    kd = (d - fd) / 32768;
    s  = kd + 1;
    mq = longint'(32768 + fd);
    if (s >= 0) mq = mq << s;
    else mq = mq >> (-s);
    r = mq[31:0];
    return {1'b0, (sg ? ~r : r)};
  endfunction

  // One clock cycle: drive at the falling edge, observe handshakes just after it
  task automatic cyc(input logic v, input logic [15:0] xx, input logic [15:0] yy, input logic ordy);
    logic [32:0] e;
    @(negedge clk);
    in_valid = v; x = xx; y = yy; out_ready = ordy;
    #1;
    if (hold_pend) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_q", q, hold_q);
      chk("hold_dbz", {31'd0, div_by_zero}, {31'd0, hold_dbz});
    end
    hold_pend = out_valid && !out_ready;
    hold_q    = q;
    hold_dbz  = div_by_zero;
    acc     = in_valid && in_ready;
    got_out = out_valid && out_ready;
    if (got_out) begin
      last_q   = q;
      last_dbz = div_by_zero;
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_q", q, e[31:0]);
        chk("sb_dbz", {31'd0, div_by_zero}, {31'd0, e[32]});
      end
    end
    if (acc) exp_q.push_back(model(xx, yy));
  endtask

  task automatic run_one(input string tag, input logic [15:0] xx, input logic [15:0] yy,
                         input logic [31:0] eq, input logic edz);
    int lat;
    bit seen;
    cyc(1'b1, xx, yy, 1'b1);
    chk({tag, "_acc"}, {31'd0, acc}, 32'd1);
    cyc(1'b0, 16'h0000, 16'h0000, 1'b1);
    lat  = 1;
    seen = got_out;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(1'b0, 16'h0000, 16'h0000, 1'b1);
      lat++;
      seen = got_out;
    end
    chk({tag, "_lat"}, lat, 32'd3);
    chk({tag, "_q"}, last_q, eq);
    chk({tag, "_dbz"}, {31'd0, last_dbz}, {31'd0, edz});
  endtask

  initial begin
    int n_acc, n_out;
    logic [15:0] rx, ry;
    logic [15:0] dx[9];
    logic [15:0] dy[9];
    logic [31:0] dq[9];
    logic        dz[9];
    dx = '{16'd12, 16'd7, 16'd3, 16'h7FFF, 16'd1, 16'hFFF3, 16'd5, 16'd5, 16'd0};
    dy = '{16'd3, 16'd2, 16'd7, 16'd1, 16'h7FFF, 16'd3, 16'h0000, 16'hFFFF, 16'd9};
    dq = '{32'h0004_0000, 32'h0003_8000, 32'h0000_7000, 32'h7FFF_0000, 32'h0000_0002,
           32'hFFFB_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    dz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; x = 16'h0000; y = 16'h0000; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_q", q, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);

    for (int i = 0; i < 9; i++) run_one($sformatf("dir%0d", i), dx[i], dy[i], dq[i], dz[i]);

    // Backpressure: stall the output and offer pairs every cycle
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0);
      if (acc) n_acc++;
    end
    chk("bp_accepts", n_acc, 32'd3);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    n_out = 0;
    cyc(1'b1, 16'd100, 16'd7, 1'b1);
    if (got_out) n_out++;
    chk("bp_shift_acc", {31'd0, acc}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 16'h0000, 16'h0000, 1'b1);
      if (got_out) n_out++;
      if (i == 2) chk("bp_one_per_cycle", n_out, 32'd4);
    end
    chk("bp_drain", n_out, 32'd4);
    chk("bp_empty", exp_q.size(), 32'd0);

    // Reset with three items in flight
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.delete();
    hold_pend = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_q", q, 32'd0);
    run_one("post_rst", 16'd12, 16'd3, 32'h0004_0000, 1'b0);

    // Random valid/ready soak with a bias towards zero operands
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0:       ry = 16'h0000;
        1:       ry = 16'hFFFF;
        default: ry = 16'($urandom);
      endcase
      rx = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), rx, ry, 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 10; i++) cyc(1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("soak_empty", exp_q.size(), 32'd0);
    chk("soak_idle", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
